// File: rtl/fp_mul_result_buffer.sv
// Elastic output stage for the FP32 multiplier: cleans overflow/underflow results to
// signed infinity/zero, queues them in a small FIFO and keeps exception statistics.
module fp_mul_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_m,
    input  logic                     in_sign,
    input  logic                     in_overflow,
    input  logic                     in_underflow,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [1:0]               out_exc,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     sticky_ovf,
    output logic                     sticky_unf,
    output logic [CNT_W-1:0]         ovf_cnt,
    output logic [CNT_W-1:0]         unf_cnt,
    input  logic                     stat_clr
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [31:0]   mem_data [DEPTH];
    logic [1:0]    mem_exc  [DEPTH];
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [31:0]   push_word;
    logic [1:0]    push_exc;

    // Extra pointer MSB distinguishes a full FIFO from an empty one
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty     = (wr_ptr == rd_ptr);
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & ~full;
    assign pop       = ~empty & out_ready;
    assign level     = wr_ptr - rd_ptr;

    // Overflow takes priority when the multiplier raises both flags
    always_comb begin
        push_word = in_m;
        push_exc  = 2'b00;
        if (in_overflow) begin
            push_word = {in_sign, 8'hFF, 23'h0};
            push_exc  = 2'b10;
        end else if (in_underflow) begin
            push_word = {in_sign, 31'h0};
            push_exc  = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr[AW-1:0]] <= push_word;
            mem_exc[wr_ptr[AW-1:0]]  <= push_exc;
        end
    end

    // Storage is not reset, so mask the head while empty to present zeros after reset
    assign out_data = empty ? 32'h0 : mem_data[rd_ptr[AW-1:0]];
    assign out_exc  = empty ? 2'b00 : mem_exc[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
            ovf_cnt    <= '0;
            unf_cnt    <= '0;
        end else if (stat_clr) begin
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
            ovf_cnt    <= '0;
            unf_cnt    <= '0;
        end else if (push) begin
            if (push_exc[1]) begin
                sticky_ovf <= 1'b1;
                if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
            end
            if (push_exc[0]) begin
                sticky_unf <= 1'b1;
                if (unf_cnt != '1) unf_cnt <= unf_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_result_buffer.sv
// Scoreboard bench for fp_mul_result_buffer: stimulus queues expected words, a negedge
// monitor compares the FIFO head, occupancy and exception statistics against the model.
module tb_fp_mul_result_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  exc;
    } entry_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_m;
    logic              in_sign;
    logic              in_overflow;
    logic              in_underflow;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [1:0]        out_exc;
    logic [LW-1:0]     level;
    logic              sticky_ovf;
    logic              sticky_unf;
    logic [CNT_W-1:0]  ovf_cnt;
    logic [CNT_W-1:0]  unf_cnt;
    logic              stat_clr;

    entry_t exp_q[$];
    int     m_ovf_cnt;
    int     m_unf_cnt;
    bit     m_sticky_ovf;
    bit     m_sticky_unf;
    int     errors;
    int     checks;

    fp_mul_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_m(in_m), .in_sign(in_sign),
        .in_overflow(in_overflow), .in_underflow(in_underflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_exc(out_exc),
        .level(level), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf),
        .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt), .stat_clr(stat_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, entered just after a rising edge; the model commits on the next edge
    task automatic apply_stimulus(input bit v, input logic [31:0] m, input bit sign,
                                  input bit ovf, input bit unf, input bit ordy, input bit clr);
        bit     accept;
        entry_t e;
        in_valid     = v;
        in_m         = m;
        in_sign      = sign;
        in_overflow  = ovf;
        in_underflow = unf;
        out_ready    = ordy;
        stat_clr     = clr;
        accept = v && (exp_q.size() < DEPTH);
        if (ovf) begin
            e.data = sign ? 32'hFF80_0000 : 32'h7F80_0000;
            e.exc  = 2'b10;
        end else if (unf) begin
            e.data = sign ? 32'h8000_0000 : 32'h0000_0000;
            e.exc  = 2'b01;
        end else begin
            e.data = m;
            e.exc  = 2'b00;
        end
        @(posedge clk);
        if (clr) begin
            m_ovf_cnt    = 0;
            m_unf_cnt    = 0;
            m_sticky_ovf = 0;
            m_sticky_unf = 0;
        end else if (accept) begin
            if (e.exc == 2'b10) begin
                m_sticky_ovf = 1;
                if (m_ovf_cnt < (1 << CNT_W) - 1) m_ovf_cnt++;
            end
            if (e.exc == 2'b01) begin
                m_sticky_unf = 1;
                if (m_unf_cnt < (1 << CNT_W) - 1) m_unf_cnt++;
            end
        end
        if (accept) exp_q.push_back(e);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_output({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check_output({tag, "_level"}, 32'(level), 32'd0);
        check_output({tag, "_out_data"}, out_data, 32'd0);
        check_output({tag, "_out_exc"}, 32'(out_exc), 32'd0);
        check_output({tag, "_ovf_cnt"}, 32'(ovf_cnt), 32'd0);
        check_output({tag, "_unf_cnt"}, 32'(unf_cnt), 32'd0);
        check_output({tag, "_sticky"}, 32'({sticky_ovf, sticky_unf}), 32'd0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for an edge
    task automatic apply_reset_mid();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        stat_clr  = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_reset_state("mid_reset");
        exp_q.delete();
        m_ovf_cnt    = 0;
        m_unf_cnt    = 0;
        m_sticky_ovf = 0;
        m_sticky_unf = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: sampled on the falling edge, between stimulus updates
    always @(negedge clk) begin
        if (rst_n) begin
            check_output("level", 32'(level), 32'(exp_q.size()));
            check_output("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
            check_output("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            check_output("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf_cnt));
            check_output("unf_cnt", 32'(unf_cnt), 32'(m_unf_cnt));
            check_output("sticky_ovf", 32'(sticky_ovf), 32'(m_sticky_ovf));
            check_output("sticky_unf", 32'(sticky_unf), 32'(m_sticky_unf));
            if (exp_q.size() > 0) begin
                check_output("out_data", out_data, exp_q[0].data);
                check_output("out_exc", 32'(out_exc), 32'(exp_q[0].exc));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        errors       = 0;
        checks       = 0;
        m_ovf_cnt    = 0;
        m_unf_cnt    = 0;
        m_sticky_ovf = 0;
        m_sticky_unf = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_m         = 32'h0;
        in_sign      = 1'b0;
        in_overflow  = 1'b0;
        in_underflow = 1'b0;
        out_ready    = 1'b0;
        stat_clr     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        rst_n = 1'b1;

        // Pass-through of 3.0, then overflow with both flags and X mantissa, then underflow
        apply_stimulus(1, 32'h4040_0000, 0, 0, 0, 0, 0);
        apply_stimulus(1, 32'hxxxx_xxxx, 1, 1, 1, 0, 0);
        apply_stimulus(1, 32'h1234_5678, 0, 0, 1, 0, 0);
        apply_stimulus(0, 32'h0, 0, 0, 0, 1, 0);
        repeat (4) apply_stimulus(0, 32'h0, 0, 0, 0, 1, 0);

        // Backpressure: five pushes into a four-deep FIFO, pop one, fifth enters, drain in order
        for (int i = 1; i <= 5; i++) apply_stimulus(1, 32'(i), 0, 0, 0, 0, 0);
        apply_stimulus(1, 32'd5, 0, 0, 0, 1, 0);
        apply_stimulus(1, 32'd5, 0, 0, 0, 0, 0);
        repeat (6) apply_stimulus(0, 32'h0, 0, 0, 0, 1, 0);

        // Counter saturation and clear colliding with an overflow push
        for (int i = 0; i < 300; i++) apply_stimulus(1, $urandom, i[0], 1, 0, 1, 0);
        apply_stimulus(0, 32'h0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 32'h0, 0, 1, 0, 0, 1);
        repeat (3) apply_stimulus(0, 32'h0, 0, 0, 0, 0, 0);
        repeat (4) apply_stimulus(0, 32'h0, 0, 0, 0, 1, 0);

        // Reset with three entries queued
        for (int i = 0; i < 3; i++) apply_stimulus(1, $urandom, 0, 0, 0, 0, 0);
        apply_reset_mid();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            apply_stimulus($urandom_range(0, 3) != 0, $urandom, 1'($urandom),
                           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                           $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0);
        end

        repeat (DEPTH + 2) apply_stimulus(0, 32'h0, 0, 0, 0, 1, 0);
        check_output("drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
